// File: rtl/terrain_pkg.sv
// Shared types and constants for the terrain column RAM arbiter.
// Column geometry, FSM states, read tags and the RMW merge helper.
package terrain_pkg;

    localparam int COL_W    = 512;
    localparam int ADDR_W   = 10;
    localparam int NUM_COLS = 640;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RMW_WAIT = 2'd1,
        RMW_WR   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_COLL = 2'd2
    } rd_tag_t;

    typedef enum logic {
        RR_COLL = 1'b0,
        RR_EDIT = 1'b1
    } rr_t;

    function automatic logic [COL_W-1:0] rmw_merge(
        input logic [COL_W-1:0] old_col,
        input logic [COL_W-1:0] mask,
        input logic [COL_W-1:0] data
    );
        return (old_col & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/terrain_arbiter_if.sv
// Requester and RAM-side signal bundle of the terrain arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface terrain_arbiter_if;
    import terrain_pkg::*;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic              coll_req;
    logic [ADDR_W-1:0] coll_addr;
    logic              coll_gnt;
    logic              coll_rvalid;
    logic              edit_req;
    logic [ADDR_W-1:0] edit_addr;
    logic [COL_W-1:0]  edit_mask;
    logic [COL_W-1:0]  edit_data;
    logic              edit_gnt;
    logic              edit_done;
    logic [COL_W-1:0]  rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [COL_W-1:0]  ram_wdata;
    logic [COL_W-1:0]  ram_rdata;
    logic              busy;

    modport slave (
        input  disp_req, disp_addr,
        input  coll_req, coll_addr,
        input  edit_req, edit_addr, edit_mask, edit_data,
        input  ram_rdata,
        output disp_rvalid, coll_gnt, coll_rvalid,
        output edit_gnt, edit_done, rdata,
        output ram_addr, ram_we, ram_wdata, busy
    );

    modport master (
        output disp_req, disp_addr,
        output coll_req, coll_addr,
        output edit_req, edit_addr, edit_mask, edit_data,
        output ram_rdata,
        input  disp_rvalid, coll_gnt, coll_rvalid,
        input  edit_gnt, edit_done, rdata,
        input  ram_addr, ram_we, ram_wdata, busy
    );

endinterface

// File: rtl/rd_tag_pipe.sv
// Delays the owner tag of each issued read by the RAM read latency,
// so the tag at the output lines up with ram_rdata.
module rd_tag_pipe
    import terrain_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    reset_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t tag_q [RD_LAT];
    rd_tag_t tag_d [RD_LAT];

    always_comb begin
        tag_d[0] = tag_in;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign tag_out = tag_q[RD_LAT-1];

endmodule

// File: rtl/terrain_arbiter.sv
// Single-port terrain RAM arbiter: display reads first, collider/editor
// round-robin, editor writes run as an atomic locked read-modify-write.
module terrain_arbiter
    import terrain_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    terrain_arbiter_if.slave   bus
);

    localparam logic [1:0] LAT2 = 2'(RD_LAT);

    arb_state_t        state_q, state_d;
    rr_t               rr_q, rr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COL_W-1:0]  mask_q, mask_d;
    logic [COL_W-1:0]  data_q, data_d;
    logic [COL_W-1:0]  wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;

    logic              idle;
    logic              disp_issue;
    logic              free;
    logic              coll_win;
    logic              edit_win;
    logic [ADDR_W-1:0] ram_addr_c;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;

    assign idle       = reset_n && (state_q == IDLE);
    assign disp_issue = idle && bus.disp_req;
    assign free       = idle && !bus.disp_req;
    assign coll_win   = free && bus.coll_req &&
                        (rr_q == RR_COLL || !bus.edit_req);
    assign edit_win   = free && bus.edit_req &&
                        (rr_q == RR_EDIT || !bus.coll_req);

    always_comb begin
        tag_in = TAG_NONE;
        unique case (1'b1)
            disp_issue: tag_in = TAG_DISP;
            coll_win:   tag_in = TAG_COLL;
            default:    tag_in = TAG_NONE;
        endcase
    end

    // Inside the lock window the address stays on the edited column.
    always_comb begin
        ram_addr_c = '0;
        if (!reset_n) begin
            ram_addr_c = '0;
        end else if (state_q != IDLE) begin
            ram_addr_c = addr_q;
        end else if (disp_issue) begin
            ram_addr_c = bus.disp_addr;
        end else if (coll_win) begin
            ram_addr_c = bus.coll_addr;
        end else if (edit_win) begin
            ram_addr_c = bus.edit_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        data_d  = data_q;
        wdata_d = '0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (coll_win) begin
                    rr_d = RR_EDIT;
                end
                if (edit_win) begin
                    rr_d    = RR_COLL;
                    addr_d  = bus.edit_addr;
                    mask_d  = bus.edit_mask;
                    data_d  = bus.edit_data;
                    cnt_d   = 2'd1;
                    state_d = RMW_WAIT;
                end
            end
            RMW_WAIT: begin
                if (cnt_q == LAT2) begin
                    wdata_d = rmw_merge(bus.ram_rdata, mask_q, data_q);
                    we_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = RMW_WR;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RMW_WR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q    <= RR_COLL;
            cnt_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign bus.coll_gnt    = coll_win;
    assign bus.edit_gnt    = edit_win;
    assign bus.disp_rvalid = reset_n && (tag_out == TAG_DISP);
    assign bus.coll_rvalid = reset_n && (tag_out == TAG_COLL);
    assign bus.rdata       = bus.ram_rdata;
    assign bus.ram_addr    = ram_addr_c;
    assign bus.ram_we      = we_q;
    assign bus.ram_wdata   = wdata_q;
    assign bus.edit_done   = done_q;
    assign bus.busy        = (state_q != IDLE);

endmodule
